// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter and its round-robin picker.
// The picker is also intended for reuse on the RX demux side.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        PASS   = 2'd2
    } arb_state_t;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

    // Width of a channel index; never narrower than one bit.
    function automatic int GRANT_W(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request bit at or after last+1,
// wrapping around. any flags that at least one request is set.
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]          req,
    input  logic [GRANT_W(NUM_CH)-1:0] last,
    output logic [GRANT_W(NUM_CH)-1:0] pick,
    output logic                       any
);

    localparam int GW = GRANT_W(NUM_CH);

    int rank;
    int best_rank;

    // Each channel gets a distance from last+1; the lowest distance with a request wins.
    always_comb begin
        pick      = '0;
        any       = 1'b0;
        rank      = 0;
        best_rank = NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
            rank = (c - int'(last) - 1 + 2 * NUM_CH) % NUM_CH;
            if (req[c] && (rank < best_rank)) begin
                best_rank = rank;
                pick      = GW'(c);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter that shares one UART TX stream between several
// AXIS byte producers, optionally prefixing each packet with a channel-ID header.
//
//   state  | meaning
//   IDLE   | no grant; sample requests and pick the next channel
//   HEADER | presenting HDR_BASE | grant until the serializer takes it
//   PASS   | granted channel wired straight through until its tlast is accepted
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int                    NUM_CH     = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    HDR_EN     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] HDR_BASE   = DATA_WIDTH'(HDR_BASE_DEFAULT)
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_CH-1:0]              s_tvalid,
    input  logic [NUM_CH-1:0]              s_tlast,
    output logic [NUM_CH-1:0]              s_tready,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic                           m_tvalid,
    output logic                           m_tlast,
    input  logic                           m_tready,
    output logic [GRANT_W(NUM_CH)-1:0]     grant,
    output logic                           busy
);

    localparam int GW = GRANT_W(NUM_CH);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_grant_q;
    logic [GW-1:0]         pick;
    logic                  any_req;
    logic [DATA_WIDTH-1:0] ch_data;
    logic                  ch_valid;
    logic                  ch_last;
    logic                  beat_done;

    rr_priority_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req  (s_tvalid),
        .last (last_grant_q),
        .pick (pick),
        .any  (any_req)
    );

    always_comb begin
        ch_data  = '0;
        ch_valid = 1'b0;
        ch_last  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == GW'(i)) begin
                ch_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                ch_valid = s_tvalid[i];
                ch_last  = s_tlast[i];
            end
        end
    end

    assign beat_done = (state_q == PASS) && ch_valid && m_tready;

    // Ready is a pure function of state, grant and m_tready, so no valid->ready loop forms.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s_tready[i] = (state_q == PASS) && (grant_q == GW'(i)) && m_tready;
        end
    end

    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        case (state_q)
            HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = HDR_BASE | DATA_WIDTH'(grant_q);
            end
            PASS: begin
                m_tvalid = ch_valid;
                m_tdata  = ch_data;
                m_tlast  = ch_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = HDR_EN ? HEADER : PASS;
            HEADER:  if (m_tready) state_d = PASS;
            PASS:    if (beat_done && ch_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to NUM_CH-1 so channel 0 is first in line after reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && any_req) begin
                grant_q <= pick;
            end
            if (beat_done && ch_last) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: randomized per-channel packet drivers, a
// packet-level arbitration model that queues expected beats, and a decoupled monitor.
module tb_uart_tx_arbiter;

    localparam int         N   = 4;
    localparam int         W   = 8;
    localparam logic [7:0] HDR = 8'hA0;

    logic           aclk = 1'b0;
    logic           areset = 1'b1;
    logic [N*W-1:0] s_tdata;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tlast;
    logic [N-1:0]   s_tready;
    logic [W-1:0]   m_tdata;
    logic           m_tvalid;
    logic           m_tlast;
    logic           m_tready;
    logic [1:0]     grant;
    logic           busy;

    logic [15:0]    s2_tdata;
    logic [1:0]     s2_tvalid;
    logic [1:0]     s2_tlast;
    logic [1:0]     s2_tready;
    logic [7:0]     m2_tdata;
    logic           m2_tvalid;
    logic           m2_tlast;
    logic           m2_tready;
    logic           grant2;
    logic           busy2;

    uart_tx_arbiter #(.NUM_CH(N), .DATA_WIDTH(W), .HDR_EN(1'b1), .HDR_BASE(HDR)) dut (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .busy(busy)
    );

    uart_tx_arbiter #(.NUM_CH(2), .DATA_WIDTH(8), .HDR_EN(1'b0), .HDR_BASE(8'hA0)) dut2 (
        .aclk(aclk), .areset(areset),
        .s_tdata(s2_tdata), .s_tvalid(s2_tvalid), .s_tlast(s2_tlast), .s_tready(s2_tready),
        .m_tdata(m2_tdata), .m_tvalid(m2_tvalid), .m_tlast(m2_tlast), .m_tready(m2_tready),
        .grant(grant2), .busy(busy2)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus store: one byte stream per channel, packets delimited by the last flag.
    logic [7:0] ch_data [N][$];
    bit         ch_last [N][$];
    int         drv_ptr [N];
    int         mdl_ptr [N];
    bit         en      [N];
    int         vprob = 100;
    int         rprob = 100;

    typedef struct {
        logic [7:0] d;
        bit         l;
        bit         h;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] obs_hdr[$];
    int         n_acc = 0;

    bit m_busy   = 1'b0;
    bit m_hdr    = 1'b0;
    int m_last   = N - 1;
    int m_grant  = 0;
    int m_remain = 0;

    task automatic add_byte(input int ch, input logic [7:0] d, input bit l);
        ch_data[ch].push_back(d);
        ch_last[ch].push_back(l);
    endtask

    task automatic add_rand_pkt(input int ch, input int len);
        for (int i = 0; i < len; i++) begin
            add_byte(ch, 8'($urandom_range(255)), (i == len - 1));
        end
    endtask

    function automatic bit drained();
        if (exp_q.size() != 0 || m_busy) return 1'b0;
        for (int c = 0; c < N; c++) begin
            if (en[c] && drv_ptr[c] < ch_data[c].size()) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge aclk);
            #1;
            ok = drained();
        end
        chk({"drain_", name}, 32'(ok), 32'd1);
    endtask

    task automatic wait_acc(input string name, input int target, input int maxc);
        int t;
        t = 0;
        while (n_acc < target && t < maxc) begin
            @(negedge aclk);
            #1;
            t++;
        end
        chk({"wait_", name}, 32'(n_acc >= target), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tdata"},  32'(m_tdata),  32'd0);
        chk({tag, "_m_tlast"},  32'(m_tlast),  32'd0);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_grant"},    32'(grant),    32'd0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        for (int c = 0; c < N; c++) begin
            ch_data[c].delete();
            ch_last[c].delete();
            drv_ptr[c] = 0;
            mdl_ptr[c] = 0;
            en[c]      = 1'b0;
        end
        exp_q.delete();
        obs_hdr.delete();
        m_busy   = 1'b0;
        m_hdr    = 1'b0;
        m_last   = N - 1;
        m_grant  = 0;
        m_remain = 0;
        n_acc    = 0;
        vprob    = 100;
        rprob    = 100;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic chk_hdr(input string name, input int idx, input logic [7:0] exp);
        chk({name, "_present"}, 32'(obs_hdr.size() > idx), 32'd1);
        if (obs_hdr.size() > idx) chk(name, 32'(obs_hdr[idx]), 32'(exp));
    endtask

    // Channel drivers: hold each byte until accepted; valid may drop randomly.
    initial begin
        bit acc [N];
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        forever begin
            @(negedge aclk);
            for (int c = 0; c < N; c++) acc[c] = s_tvalid[c] && s_tready[c];
            @(posedge aclk);
            #1;
            if (areset) begin
                s_tvalid = '0;
                s_tlast  = '0;
                m_tready = 1'b0;
            end else begin
                for (int c = 0; c < N; c++) begin
                    if (acc[c]) drv_ptr[c]++;
                    if (en[c] && drv_ptr[c] < ch_data[c].size() &&
                        $urandom_range(99) < vprob) begin
                        s_tvalid[c]          = 1'b1;
                        s_tdata[c*W +: W]    = ch_data[c][drv_ptr[c]];
                        s_tlast[c]           = ch_last[c][drv_ptr[c]];
                    end else begin
                        s_tvalid[c] = 1'b0;
                        s_tlast[c]  = 1'b0;
                    end
                end
                m_tready = ($urandom_range(99) < rprob);
            end
        end
    end

    // Reference model: packet-level round robin, queues header + whole packet on each grant.
    initial begin
        int   best;
        int   c;
        exp_t e;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                if (!m_busy) begin
                    chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);
                    chk("idle_s_tready", 32'(s_tready), 32'd0);
                    chk("idle_busy",     32'(busy),     32'd0);
                    chk("idle_grant",    32'(grant),    32'(m_grant));
                    best = -1;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (best < 0 && s_tvalid[c]) best = c;
                    end
                    if (best >= 0) begin
                        m_grant  = best;
                        m_busy   = 1'b1;
                        m_hdr    = 1'b1;
                        m_remain = 0;
                        e.d = HDR | 8'(best);
                        e.l = 1'b0;
                        e.h = 1'b1;
                        exp_q.push_back(e);
                        e.l = 1'b0;
                        while (!e.l && mdl_ptr[best] < ch_data[best].size()) begin
                            e.d = ch_data[best][mdl_ptr[best]];
                            e.l = ch_last[best][mdl_ptr[best]];
                            e.h = 1'b0;
                            exp_q.push_back(e);
                            mdl_ptr[best]++;
                            m_remain++;
                        end
                    end
                end else begin
                    chk("busy",  32'(busy),  32'd1);
                    chk("grant", 32'(grant), 32'(m_grant));
                    if (m_hdr) begin
                        chk("hdr_m_tvalid", 32'(m_tvalid), 32'd1);
                        chk("hdr_s_tready", 32'(s_tready), 32'd0);
                        if (m_tready) m_hdr = 1'b0;
                    end else begin
                        chk("pass_m_tvalid", 32'(m_tvalid), 32'(s_tvalid[m_grant]));
                        chk("pass_s_tready", 32'(s_tready),
                            m_tready ? (32'd1 << m_grant) : 32'd0);
                        if (s_tvalid[m_grant] && m_tready) begin
                            m_remain--;
                            if (m_remain == 0) begin
                                m_busy = 1'b0;
                                m_last = m_grant;
                            end
                        end
                    end
                end
            end
        end
    end

    // Monitor: every accepted master beat is matched against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (!areset && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (t=%0t)",
                             m_tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(m_tdata), 32'(e.d));
                    chk("beat_last", 32'(m_tlast), 32'(e.l));
                    if (e.h) obs_hdr.push_back(m_tdata);
                end
                n_acc++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s2_tdata  = '0;
        s2_tvalid = '0;
        s2_tlast  = '0;
        m2_tready = 1'b0;
        areset    = 1'b1;
        #12;
        reset_checks("rst");
        chk("rst_dut2_m_tvalid", 32'(m2_tvalid), 32'd0);
        chk("rst_dut2_busy",     32'(busy2),     32'd0);
        do_reset();

        // No-header, two-channel instance: first beat one cycle after the sampling edge.
        @(posedge aclk);
        #1;
        s2_tvalid = 2'b10;
        s2_tdata  = 16'h5500;
        s2_tlast  = 2'b10;
        m2_tready = 1'b1;
        @(negedge aclk);
        chk("nohdr_pre_valid", 32'(m2_tvalid), 32'd0);
        @(negedge aclk);
        chk("nohdr_valid",    32'(m2_tvalid), 32'd1);
        chk("nohdr_data",     32'(m2_tdata),  32'h55);
        chk("nohdr_last",     32'(m2_tlast),  32'd1);
        chk("nohdr_grant",    32'(grant2),    32'd1);
        chk("nohdr_s_tready", 32'(s2_tready), 32'b10);
        @(posedge aclk);
        #1;
        s2_tvalid = 2'b00;
        s2_tlast  = 2'b00;
        @(negedge aclk);
        chk("nohdr_after_busy",  32'(busy2),     32'd0);
        chk("nohdr_after_valid", 32'(m2_tvalid), 32'd0);

        // Single packet on ch2.
        add_byte(2, 8'h11, 1'b0);
        add_byte(2, 8'h22, 1'b0);
        add_byte(2, 8'h33, 1'b1);
        en[2] = 1'b1;
        wait_drain("single", 50);
        chk("single_grant", 32'(grant), 32'd2);
        chk_hdr("single_hdr", 0, 8'hA2);

        // All four channels at once after reset.
        @(posedge aclk);
        #2;
        do_reset();
        for (int c = 0; c < N; c++) add_byte(c, 8'(8'h10 + c), 1'b1);
        for (int c = 0; c < N; c++) en[c] = 1'b1;
        wait_drain("all4", 100);
        for (int c = 0; c < N; c++) chk_hdr("all4_hdr", c, HDR | 8'(c));

        // Backpressure on a 5-byte ch1 packet.
        rprob = 50;
        add_rand_pkt(1, 5);
        en[1] = 1'b1;
        wait_drain("bp", 300);

        // Fairness: ch3 shows up mid-packet while ch1 streams back-to-back.
        rprob = 100;
        obs_hdr.delete();
        n_acc = 0;
        add_rand_pkt(1, 4);
        add_rand_pkt(1, 4);
        wait_acc("fair", 2, 100);
        add_rand_pkt(3, 2);
        en[3] = 1'b1;
        wait_drain("fair", 200);
        chk_hdr("fair_hdr0", 0, 8'hA1);
        chk_hdr("fair_hdr1", 1, 8'hA3);
        chk_hdr("fair_hdr2", 2, 8'hA1);

        // Random traffic on all channels.
        rprob = 60;
        vprob = 70;
        for (int c = 0; c < N; c++) begin
            for (int p = 0; p < 3; p++) add_rand_pkt(c, $urandom_range(6, 1));
        end
        for (int c = 0; c < N; c++) en[c] = 1'b1;
        wait_drain("random", 3000);

        // Reset in the middle of a packet.
        @(posedge aclk);
        #2;
        do_reset();
        add_rand_pkt(2, 5);
        en[2] = 1'b1;
        wait_acc("midrst", 2, 100);
        @(posedge aclk);
        #1;
        chk("midrst_pre_valid", 32'(m_tvalid), 32'd1);
        #1;
        areset = 1'b1;
        #1;
        reset_checks("midrst");
        do_reset();
        add_byte(0, 8'h01, 1'b1);
        add_byte(3, 8'h03, 1'b1);
        en[0] = 1'b1;
        en[3] = 1'b1;
        wait_drain("postrst", 100);
        chk_hdr("postrst_hdr0", 0, 8'hA0);
        chk_hdr("postrst_hdr1", 1, 8'hA3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares one UART transmit path between several AXI-Stream byte producers. It sits directly upstream of the AXIS-to-UART serializer. It grants one requester at a time, optionally prefixes each packet with a channel-ID header byte, and holds the grant until that requester's `tlast` beat is accepted, so packets from different sources never interleave on the serial line.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting AXIS slave channels, 2..16
- `DATA_WIDTH`, 8: byte width, must be >= `$clog2(NUM_CH)`
- `HDR_EN`, 1: 1 = insert header byte before each packet, 0 = no header
- `HDR_BASE`, 8'hA0: header value; its low `$clog2(NUM_CH)` bits must be zero

Ports:
- `aclk`  in  1  clock; the only clock
- `areset`  in  1  reset, asynchronous, active-high
- `s_tdata`  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `s_tvalid`  in  NUM_CH  per-channel valid
- `s_tlast`  in  NUM_CH  per-channel end of packet
- `s_tready`  out  NUM_CH  per-channel ready
- `m_tdata`  out  DATA_WIDTH  to UART TX serializer
- `m_tvalid`  out  1  master valid
- `m_tlast`  out  1  end of packet, forwarded from the granted channel
- `m_tready`  in  1  serializer ready
- `grant`  out  $clog2(NUM_CH)  index of the current or last granted channel
- `busy`  out  1  high in HEADER or PASS

## Operation
- FSM states: IDLE, HEADER, PASS.
- IDLE:
  - `m_tvalid`=0 and all `s_tready`=0.
  - If any `s_tvalid` is high, pick the first set bit scanning from `(last_grant+1) mod NUM_CH` upward with wrap.
  - Register that index into `grant`.
  - Next state is HEADER if `HDR_EN`, else PASS.
- HEADER:
  - `m_tvalid`=1, `m_tdata`=`HDR_BASE | grant`, `m_tlast`=0.
  - On `m_tready`, go to PASS.
- PASS:
  - `m_tdata`, `m_tvalid` and `m_tlast` are combinationally taken from channel `grant`.
  - `s_tready[grant]`=`m_tready`; all other `s_tready`=0.
  - When a beat is accepted (`s_tvalid[grant] & m_tready`) with `s_tlast[grant]`=1: go to IDLE and set `last_grant <= grant`.
- The grant is never revoked mid-packet. A stalled requester (`s_tvalid` low) holds the bus indefinitely.
- Requests that drop in IDLE before being sampled are ignored; only the sampled vector decides the grant.
- A channel whose `s_tvalid` falls in PASS produces `m_tvalid`=0. No beat is emitted, duplicated or lost.

## Timing
- Reset values (asynchronous): state=IDLE, `grant`=0, `last_grant`=NUM_CH-1 (channel 0 gets first priority), `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, all `s_tready`=0, `busy`=0.
- Request in IDLE at edge N:
  - `HDR_EN`=1: header valid from cycle N+1.
  - `HDR_EN`=0: first data beat is presented from cycle N+1.
- Throughput in PASS: 1 beat/cycle, fully bound by `m_tready`.
- Packet turnaround: exactly one IDLE bubble cycle after each accepted `tlast`.
- Simultaneous `tlast` acceptance and new requests: the new grant is decided in the following IDLE cycle, using the updated `last_grant`.
- `areset` mid-packet: all outputs drop immediately. The partial packet is abandoned; downstream framing recovery is not this block's job.
- Ready path `m_tready` -> `s_tready` is combinational. There is no valid-on-ready combinational loop.

## Structure
- Package `uart_arb_pkg` holds:
  - FSM enum type `arb_state_t` {IDLE, HEADER, PASS}
  - default `HDR_BASE` constant
  - width helper `GRANT_W(NUM_CH)`
- Sub-module `rr_priority_picker`: purely combinational, with inputs `req[NUM_CH]` and `last[GRANT_W]`, and outputs `pick[GRANT_W]` and `any`. It is reusable by the RX demux side.
- The top level contains the FSM, the registered `grant`/`last_grant`, and the output muxes.

## Test plan
- Single channel: ch2 sends 0x11, 0x22, 0x33 (`tlast` on 0x33) with `m_tready`=1 -> master sees A2, 11, 22, 33 with `m_tlast` only on 33; `grant`=2; `busy` is high for 4 cycles, then 1 IDLE cycle.
- All four channels request single-byte packets at once after reset -> headers in order A0, A1, A2, A3, each followed by its byte, with 1 bubble between packets.
- Backpressure: ch1 sends a 5-byte packet while `m_tready` follows a random 50% pattern -> output is an exact, in-order copy of the input; `s_tready[1]` tracks `m_tready`; other `s_tready` stay 0.
- Fairness: ch1 streams back-to-back packets; ch3 raises valid during ch1's packet -> ch3 is granted immediately after ch1's `tlast`, before ch1 is granted again.
- Reset mid-packet: assert `areset` after the 2nd beat -> all outputs 0 in the same cycle; after release, a request on ch0 and ch3 grants ch0 first.
- `HDR_EN`=0, `NUM_CH`=2: ch1 sends 0x55 (`tlast`) -> the first master beat is 0x55 one cycle after the request is sampled; no header appears.
